// File: rtl/harmonic_accumulator.sv
// harmonic_accumulator: sums level-scaled harmonic sine samples into L/R frame samples for the DAC output stage (optional STEREO_SPLIT_EN: even harmonics to L, odd to R)
module harmonic_accumulator #(
    parameter int MAX_HARMONICS = 256,
    parameter int COUNT_BITS    = 9,
    parameter int LEVEL_SHIFT   = 16
) (
    input  logic        i_Clock,
    input  logic        i_Reset_N,
    input  logic        i_Frame_Start,
    input  logic        i_Harmonic_Valid,
    input  logic [15:0] i_Harmonic_Sample,
    input  logic [15:0] i_Harmonic_Level,
    input  logic        i_Harmonic_Last,
    input  logic        i_Out_Ready,
    output logic [31:0] o_Sample_L,
    output logic [31:0] o_Sample_R,
    output logic        o_Start,
    output logic        o_Overrun,
    output logic        o_Busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]            state, state_next;
    logic [COUNT_BITS-1:0] count;
    logic                  drain_cnt;
    logic                  frame_clear, accept, emit;
    logic signed [32:0]    product_d, product;
    logic                  p_valid;
    logic [31:0]           term;
    logic [31:0]           acc_l;
`ifdef STEREO_SPLIT_EN
    logic                  idx_odd, p_odd;
    logic [31:0]           acc_r;
`endif

    // next-state, acceptance and product/term decode
    always_comb begin
        frame_clear = i_Frame_Start && (state == IDLE || state == ACCUM);
        accept      = (state == ACCUM) && i_Harmonic_Valid &&
                      (i_Frame_Start || count < COUNT_BITS'(MAX_HARMONICS));
        emit        = (state == HOLD) && i_Out_Ready;
        state_next  = (state == IDLE)  ? (i_Frame_Start ? ACCUM : IDLE) :
                      (state == ACCUM) ? ((i_Harmonic_Valid && i_Harmonic_Last) ? DRAIN : ACCUM) :
                      (state == DRAIN) ? (drain_cnt ? HOLD : DRAIN) :
                                         (i_Out_Ready ? IDLE : HOLD);
        product_d   = 33'($signed(i_Harmonic_Sample)) * 33'($signed({1'b0, i_Harmonic_Level}));
        term        = 32'(product >>> LEVEL_SHIFT);
`ifdef STEREO_SPLIT_EN
        idx_odd     = i_Frame_Start ? 1'b0 : count[0];
`endif
    end

    // FSM, accepted-harmonic counter (also the harmonic index) and two-cycle drain timer
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state     <= IDLE;
            count     <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= frame_clear ? COUNT_BITS'(accept) : count + COUNT_BITS'(accept);
            drain_cnt <= (state == DRAIN) && !drain_cnt;
        end
    end

    // stage 1: register the signed sample x unsigned level product
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            p_valid <= 1'b0;
            product <= '0;
`ifdef STEREO_SPLIT_EN
            p_odd   <= 1'b0;
`endif
        end else begin
            p_valid <= accept;
            if (accept) product <= product_d;
`ifdef STEREO_SPLIT_EN
            if (accept) p_odd <= idx_odd;
`endif
        end
    end

    // stage 2: accumulate the shifted term; a frame start discards anything still in flight
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            acc_l <= '0;
`ifdef STEREO_SPLIT_EN
            acc_r <= '0;
`endif
        end else if (frame_clear) begin
            acc_l <= '0;
`ifdef STEREO_SPLIT_EN
            acc_r <= '0;
`endif
        end else if (p_valid) begin
`ifdef STEREO_SPLIT_EN
            if (p_odd) acc_r <= acc_r + term;
            else acc_l <= acc_l + term;
`else
            acc_l <= acc_l + term;
`endif
        end
    end

    // hand the finished frame to the output stage and flag aborted or dropped frames
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            o_Start    <= 1'b0;
            o_Overrun  <= 1'b0;
            o_Sample_L <= '0;
`ifdef STEREO_SPLIT_EN
            o_Sample_R <= '0;
`endif
        end else begin
            o_Start   <= emit;
            o_Overrun <= i_Frame_Start && (state != IDLE);
            if (emit) o_Sample_L <= acc_l;
`ifdef STEREO_SPLIT_EN
            if (emit) o_Sample_R <= acc_r;
`endif
        end
    end

`ifndef STEREO_SPLIT_EN
    assign o_Sample_R = o_Sample_L;
`endif
    assign o_Busy = (state != IDLE);

endmodule
